// File: rtl/idma_read_port_mux_pkg.sv
// Shared types for the iDMA N-way read-port multiplexer.
package idma_read_port_mux_pkg;

  localparam int unsigned NumReadPortsMax = 16;
  localparam int unsigned PortIdxW        = $clog2(NumReadPortsMax);

  // Wide enough for any legal port count, so both order FIFOs share one type
  typedef logic [PortIdxW-1:0] port_idx_t;
  typedef logic [7:0]          byte_t;

  function automatic int unsigned port_idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idma_read_port_mux_if.sv
// Handshake and data bundle between the backend, the read ports and the mux.
interface idma_read_port_mux_if
  import idma_read_port_mux_pkg::*;
#(
  parameter int unsigned NumPorts   = 2,
  parameter int unsigned StrbWidth  = 2,
  parameter type         r_dp_rsp_t = logic
);

  logic                                 meta_valid_i;
  logic                                 meta_ready_o;
  logic      [NumPorts-1:0]             port_meta_valid_o;
  logic      [NumPorts-1:0]             port_meta_ready_i;
  logic                                 r_dp_valid_i;
  logic                                 r_dp_ready_o;
  logic      [NumPorts-1:0]             port_r_dp_valid_o;
  logic      [NumPorts-1:0]             port_r_dp_ready_i;
  r_dp_rsp_t [NumPorts-1:0]             port_r_dp_rsp_i;
  logic      [NumPorts-1:0]             port_r_dp_rsp_valid_i;
  logic      [NumPorts-1:0]             port_r_dp_rsp_ready_o;
  r_dp_rsp_t                            r_dp_rsp_o;
  logic                                 r_dp_rsp_valid_o;
  logic                                 r_dp_rsp_ready_i;
  byte_t     [NumPorts-1:0][StrbWidth-1:0] port_buffer_in_i;
  logic      [NumPorts-1:0][StrbWidth-1:0] port_buffer_in_valid_i;
  logic      [NumPorts-1:0][StrbWidth-1:0] port_buffer_in_ready_o;
  byte_t     [StrbWidth-1:0]            buffer_in_o;
  logic      [StrbWidth-1:0]            buffer_in_valid_o;
  logic      [StrbWidth-1:0]            buffer_in_ready_i;
  logic                                 busy_o;

  modport slave (
    input  meta_valid_i, port_meta_ready_i, r_dp_valid_i, port_r_dp_ready_i,
           port_r_dp_rsp_i, port_r_dp_rsp_valid_i, r_dp_rsp_ready_i,
           port_buffer_in_i, port_buffer_in_valid_i, buffer_in_ready_i,
    output meta_ready_o, port_meta_valid_o, r_dp_ready_o, port_r_dp_valid_o,
           port_r_dp_rsp_ready_o, r_dp_rsp_o, r_dp_rsp_valid_o,
           port_buffer_in_ready_o, buffer_in_o, buffer_in_valid_o, busy_o
  );

  modport master (
    output meta_valid_i, port_meta_ready_i, r_dp_valid_i, port_r_dp_ready_i,
           port_r_dp_rsp_i, port_r_dp_rsp_valid_i, r_dp_rsp_ready_i,
           port_buffer_in_i, port_buffer_in_valid_i, buffer_in_ready_i,
    input  meta_ready_o, port_meta_valid_o, r_dp_ready_o, port_r_dp_valid_o,
           port_r_dp_rsp_ready_o, r_dp_rsp_o, r_dp_rsp_valid_o,
           port_buffer_in_ready_o, buffer_in_o, buffer_in_valid_o, busy_o
  );

endinterface

// File: rtl/idma_read_port_mux_order_fifo.sv
// Small FIFO of port indices that remembers which port owns each in-flight transfer.
module idma_read_port_mux_order_fifo
  import idma_read_port_mux_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  port_idx_t data_i,
  input  logic      pop_i,
  output port_idx_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;

  port_idx_t       mem_q [Depth];
  ptr_t            wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Explicit wrap keeps non-power-of-two depths correct
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = ptr_inc(wr_q);
    if (pop_i)  rd_d = ptr_inc(rd_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/idma_read_port_mux.sv
// Round-robin distribution of read meta requests over N read ports, with
// datapath requests, data and responses steered back strictly in issue order.
module idma_read_port_mux
  import idma_read_port_mux_pkg::*;
#(
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned NumAxInFlight = 2,
  parameter int unsigned StrbWidth     = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  idma_read_port_mux_if.slave bus
);

  localparam int unsigned PW = port_idx_width(NumPorts);

  logic [PW-1:0] rr_q, rr_d;
  logic          meta_push, meta_pop, meta_full, meta_empty;
  logic          dp_push, dp_pop, dp_full, dp_empty;
  port_idx_t     meta_head, dp_head;

  idma_read_port_mux_order_fifo #(.Depth(NumAxInFlight)) i_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (meta_push),
    .data_i  (port_idx_t'(rr_q)),
    .pop_i   (meta_pop),
    .data_o  (meta_head),
    .full_o  (meta_full),
    .empty_o (meta_empty)
  );

  idma_read_port_mux_order_fifo #(.Depth(NumAxInFlight)) i_dp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (dp_push),
    .data_i  (meta_head),
    .pop_i   (dp_pop),
    .data_o  (dp_head),
    .full_o  (dp_full),
    .empty_o (dp_empty)
  );

  // Meta: only the round-robin target sees the request; a busy target stalls it
  always_comb begin
    bus.port_meta_valid_o = '0;
    bus.meta_ready_o      = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (rr_q == PW'(p)) begin
        bus.port_meta_valid_o[p] = bus.meta_valid_i & ~meta_full;
        bus.meta_ready_o         = bus.port_meta_ready_i[p] & ~meta_full;
      end
    end
  end

  assign meta_push = bus.meta_valid_i & bus.meta_ready_o;
  assign rr_d      = !meta_push ? rr_q :
                     (rr_q == PW'(NumPorts - 1)) ? '0 : rr_q + PW'(1);

  always_comb begin
    bus.port_r_dp_valid_o = '0;
    bus.r_dp_ready_o      = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (meta_head == port_idx_t'(p)) begin
        bus.port_r_dp_valid_o[p] = bus.r_dp_valid_i & ~meta_empty & ~dp_full;
        bus.r_dp_ready_o         = bus.port_r_dp_ready_i[p] & ~meta_empty & ~dp_full;
      end
    end
  end

  assign dp_push  = bus.r_dp_valid_i & bus.r_dp_ready_o;
  assign meta_pop = dp_push;

  // Data and response: only the oldest outstanding port is connected
  always_comb begin
    bus.buffer_in_o            = '0;
    bus.buffer_in_valid_o      = '0;
    bus.port_buffer_in_ready_o = '0;
    bus.r_dp_rsp_o             = '0;
    bus.r_dp_rsp_valid_o       = 1'b0;
    bus.port_r_dp_rsp_ready_o  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (!dp_empty && (dp_head == port_idx_t'(p))) begin
        bus.buffer_in_o               = bus.port_buffer_in_i[p];
        bus.buffer_in_valid_o         = bus.port_buffer_in_valid_i[p];
        bus.port_buffer_in_ready_o[p] = bus.buffer_in_ready_i;
        bus.r_dp_rsp_o                = bus.port_r_dp_rsp_i[p];
        bus.r_dp_rsp_valid_o          = bus.port_r_dp_rsp_valid_i[p];
        bus.port_r_dp_rsp_ready_o[p]  = bus.r_dp_rsp_ready_i;
      end
    end
  end

  assign dp_pop     = bus.r_dp_rsp_valid_o & bus.r_dp_rsp_ready_i;
  assign bus.busy_o = ~meta_empty | ~dp_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  a_num_ports: assert property (@(posedge clk_i)
    (NumPorts >= 1) && (NumPorts <= NumReadPortsMax));

endmodule

// File: tb/tb_idma_read_port_mux.sv
// Self-checking bench for idma_read_port_mux with three ports and two-deep order FIFOs.
module tb_idma_read_port_mux;

  localparam int NP  = 3;
  localparam int NAX = 2;
  localparam int SW  = 2;

  typedef logic [7:0] rsp_t;

  typedef struct {
    logic       mv;
    logic [2:0] mr;
    logic       dv;
    logic [2:0] pmv;
    logic       emr;
    logic [2:0] dpv;
    logic       rspv;
    logic       busy;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idma_read_port_mux_if #(.NumPorts(NP), .StrbWidth(SW), .r_dp_rsp_t(rsp_t)) bus ();

  idma_read_port_mux #(.NumPorts(NP), .NumAxInFlight(NAX), .StrbWidth(SW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int   npass  = 0;
  int   ntotal = 0;
  rsp_t exp_q[$];
  vec_t vecs[$];
  int   model_rr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: responses must leave in the order the meta requests were issued
  always @(negedge clk) begin
    #4;
    if (rst_n && bus.r_dp_rsp_valid_o && bus.r_dp_rsp_ready_i) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", {63'd0, bus.r_dp_rsp_valid_o}, 64'd0);
      else begin : pop_blk
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_order", {56'd0, bus.r_dp_rsp_o}, {56'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.meta_valid_i           = 1'b0;
    bus.port_meta_ready_i      = 3'b110;
    bus.r_dp_valid_i           = 1'b0;
    bus.port_r_dp_ready_i      = 3'b111;
    bus.port_r_dp_rsp_i        = {8'hA2, 8'hA1, 8'hA0};
    bus.port_r_dp_rsp_valid_i  = 3'b111;
    bus.r_dp_rsp_ready_i       = 1'b1;
    bus.port_buffer_in_i       = '0;
    bus.port_buffer_in_valid_i = '0;
    bus.buffer_in_ready_i      = 2'b11;

    // mv, mr, dv | pmv, meta_ready, dpv, rspv, busy
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 3'b000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 3'b001, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 3'b010, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 3'b100, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'b111, 1'b1, 3'b000, 1'b1, 3'b001, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'b111, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0});
    for (int k = 0; k < 5; k++)
      vecs.push_back(vec_t'{1'b1, 3'b101, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b0, 3'b010, 1'b1, 3'b000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'b111, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 3'b100, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'b111, 1'b1, 3'b000, 1'b1, 3'b001, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'b111, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0});

    @(negedge clk); #1;
    chk("rst_busy",       {63'd0, bus.busy_o}, 64'd0);
    chk("rst_pmv",        {61'd0, bus.port_meta_valid_o}, 64'd0);
    chk("rst_meta_ready", {63'd0, bus.meta_ready_o}, 64'd0);
    chk("rst_dp_ready",   {63'd0, bus.r_dp_ready_o}, 64'd0);
    chk("rst_rspv",       {63'd0, bus.r_dp_rsp_valid_o}, 64'd0);
    chk("rst_buf",        {48'd0, bus.buffer_in_o}, 64'd0);
    bus.port_meta_ready_i = 3'b001;
    #1;
    chk("rst_meta_ready_p0", {63'd0, bus.meta_ready_o}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.port_meta_ready_i = 3'b111;

    // Round robin, stall on port 1, full meta FIFO, drain
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.meta_valid_i      = vecs[i].mv;
      bus.port_meta_ready_i = vecs[i].mr;
      bus.r_dp_valid_i      = vecs[i].dv;
      #1;
      chk($sformatf("row%0d_pmv", i),  {61'd0, bus.port_meta_valid_o}, {61'd0, vecs[i].pmv});
      chk($sformatf("row%0d_mrdy", i), {63'd0, bus.meta_ready_o},      {63'd0, vecs[i].emr});
      chk($sformatf("row%0d_dpv", i),  {61'd0, bus.port_r_dp_valid_o}, {61'd0, vecs[i].dpv});
      chk($sformatf("row%0d_rspv", i), {63'd0, bus.r_dp_rsp_valid_o},  {63'd0, vecs[i].rspv});
      chk($sformatf("row%0d_busy", i), {63'd0, bus.busy_o},            {63'd0, vecs[i].busy});
      if (vecs[i].mv && vecs[i].emr) begin
        exp_q.push_back(rsp_t'(8'hA0 + model_rr));
        model_rr = (model_rr == NP - 1) ? 0 : model_rr + 1;
      end
    end

    // Reset with two requests outstanding
    @(negedge clk);
    bus.meta_valid_i = 1'b1;
    bus.r_dp_valid_i = 1'b0;
    #1 chk("pre_rst_pmv1", {61'd0, bus.port_meta_valid_o}, 64'b010);
    @(negedge clk);
    #1 chk("pre_rst_pmv2", {61'd0, bus.port_meta_valid_o}, 64'b100);
    @(negedge clk);
    bus.meta_valid_i = 1'b0;
    #1 chk("pre_rst_busy", {63'd0, bus.busy_o}, 64'd1);
    rst_n = 1'b0;
    bus.r_dp_valid_i = 1'b1;
    #1;
    chk("mid_rst_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("mid_rst_pmv",  {61'd0, bus.port_meta_valid_o}, 64'd0);
    chk("mid_rst_dpv",  {61'd0, bus.port_r_dp_valid_o}, 64'd0);
    chk("mid_rst_rspv", {63'd0, bus.r_dp_rsp_valid_o}, 64'd0);
    chk("mid_rst_dprdy", {63'd0, bus.r_dp_ready_o}, 64'd0);
    exp_q.delete();

    @(negedge clk);
    rst_n = 1'b1;
    bus.meta_valid_i = 1'b1;
    bus.r_dp_valid_i = 1'b0;
    bus.port_r_dp_rsp_valid_i = 3'b000;
    #1 chk("post_rst_pmv", {61'd0, bus.port_meta_valid_o}, 64'b001);
    exp_q.push_back(8'hA0);

    // Data steering and response ordering: port 0 then port 1
    @(negedge clk);
    bus.r_dp_valid_i = 1'b1;
    #1;
    chk("steer_pmv", {61'd0, bus.port_meta_valid_o}, 64'b010);
    chk("steer_dpv0", {61'd0, bus.port_r_dp_valid_o}, 64'b001);
    exp_q.push_back(8'hA1);

    @(negedge clk);
    bus.meta_valid_i = 1'b0;
    bus.port_buffer_in_i       = {16'h0000, 16'hBEEF, 16'h1234};
    bus.port_buffer_in_valid_i = 6'b001111;
    bus.port_r_dp_rsp_valid_i  = 3'b010;
    #1;
    chk("steer_dpv1",  {61'd0, bus.port_r_dp_valid_o}, 64'b010);
    chk("buf_p0_a",    {48'd0, bus.buffer_in_o}, 64'h1234);
    chk("bufv_p0_a",   {62'd0, bus.buffer_in_valid_o}, 64'b11);
    chk("bufrdy_p0_a", {58'd0, bus.port_buffer_in_ready_o}, 64'b000011);
    chk("rspv_wait_a", {63'd0, bus.r_dp_rsp_valid_o}, 64'd0);
    chk("rsprdy_p0_a", {61'd0, bus.port_r_dp_rsp_ready_o}, 64'b001);

    @(negedge clk);
    bus.r_dp_valid_i = 1'b0;
    #1;
    chk("buf_p0_b",    {48'd0, bus.buffer_in_o}, 64'h1234);
    chk("bufrdy_p0_b", {58'd0, bus.port_buffer_in_ready_o}, 64'b000011);
    chk("rspv_wait_b", {63'd0, bus.r_dp_rsp_valid_o}, 64'd0);

    @(negedge clk);
    bus.port_r_dp_rsp_valid_i = 3'b011;
    #1;
    chk("rspv_p0", {63'd0, bus.r_dp_rsp_valid_o}, 64'd1);
    chk("rsp_p0",  {56'd0, bus.r_dp_rsp_o}, 64'hA0);

    @(negedge clk);
    bus.port_r_dp_rsp_valid_i = 3'b000;
    #1;
    chk("buf_p1",    {48'd0, bus.buffer_in_o}, 64'hBEEF);
    chk("bufrdy_p1", {58'd0, bus.port_buffer_in_ready_o}, 64'b001100);
    chk("rsprdy_p1", {61'd0, bus.port_r_dp_rsp_ready_o}, 64'b010);
    chk("rspv_p1_idle", {63'd0, bus.r_dp_rsp_valid_o}, 64'd0);

    @(negedge clk);
    bus.port_r_dp_rsp_valid_i = 3'b010;
    #1;
    chk("rspv_p1", {63'd0, bus.r_dp_rsp_valid_o}, 64'd1);
    chk("rsp_p1",  {56'd0, bus.r_dp_rsp_o}, 64'hA1);

    @(negedge clk);
    bus.port_r_dp_rsp_valid_i = 3'b000;
    #1;
    chk("empty_buf",    {48'd0, bus.buffer_in_o}, 64'd0);
    chk("empty_bufv",   {62'd0, bus.buffer_in_valid_o}, 64'd0);
    chk("empty_bufrdy", {58'd0, bus.port_buffer_in_ready_o}, 64'd0);
    chk("empty_busy",   {63'd0, bus.busy_o}, 64'd0);
    chk("sb_drained",   64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/idma_read_port_mux.md
Name: idma_read_port_mux

Overview:
- Generalised N-way read-port multiplexer for the iDMA transport layer.
- Distributes read meta requests round-robin over NumPorts read-protocol instances (e.g. several AXI read managers).
- Records each issued port in order FIFOs, then steers datapath requests, buffer data and datapath responses to and from the owning port, strictly in issue order.
- Sits between the backend's meta/datapath handshakes and the per-port read units, ahead of the read barrel shifter.

Parameters:
- NumPorts, 2, number of read ports; legal range 1..16.
- NumAxInFlight, 2, depth of each order FIFO; must be at least 1.
- StrbWidth, 2, bytes per beat.
- byte_t, logic [7:0], byte type.
- strb_t, logic, StrbWidth-bit mask type.
- r_dp_rsp_t, logic, read datapath response struct.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- meta_valid_i  in  1  upstream meta request valid.
- meta_ready_o  out  1  upstream meta request ready.
- port_meta_valid_o  out  NumPorts  per-port meta valid.
- port_meta_ready_i  in  NumPorts  per-port meta ready.
- r_dp_valid_i  in  1  upstream datapath request valid.
- r_dp_ready_o  out  1  upstream datapath request ready.
- port_r_dp_valid_o  out  NumPorts  per-port datapath request valid.
- port_r_dp_ready_i  in  NumPorts  per-port datapath request ready.
- port_r_dp_rsp_i  in  NumPorts x r_dp_rsp_t  per-port datapath responses.
- port_r_dp_rsp_valid_i  in  NumPorts  per-port response valid.
- port_r_dp_rsp_ready_o  out  NumPorts  per-port response ready.
- r_dp_rsp_o  out  r_dp_rsp_t  muxed response.
- r_dp_rsp_valid_o  out  1  muxed response valid.
- r_dp_rsp_ready_i  in  1  muxed response ready.
- port_buffer_in_i  in  NumPorts x StrbWidth x 8  per-port data.
- port_buffer_in_valid_i  in  NumPorts x StrbWidth  per-port byte valids.
- port_buffer_in_ready_o  out  NumPorts x StrbWidth  per-port byte readies.
- buffer_in_o  out  StrbWidth x 8  muxed data to the shifter.
- buffer_in_valid_o  out  StrbWidth  muxed byte valids.
- buffer_in_ready_i  in  StrbWidth  buffer byte readies.
- busy_o  out  1  any transfer outstanding.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on rst_ni.
  - Reset clears the round-robin pointer rr_q and both FIFOs to empty.
  - After reset: all valid outputs 0, meta_ready_o = port_meta_ready_i[0], r_dp_ready_o 0, busy_o 0, data and response outputs '0.
- Port index width: PW = max(1, $clog2(NumPorts)). rr_q wraps from NumPorts-1 to 0; this must hold for non-power-of-two NumPorts.
- Meta stage:
  - port_meta_valid_o[rr_q] = meta_valid_i & !meta_fifo_full; all other ports get 0.
  - meta_ready_o = port_meta_ready_i[rr_q] & !meta_fifo_full.
  - On a handshake: push rr_q into meta_fifo and advance rr_q by 1.
  - No skipping: if the target port is not ready, the request stalls.
- Datapath-request stage:
  - Head h = meta_fifo head.
  - port_r_dp_valid_o[h] = r_dp_valid_i & !meta_fifo_empty & !dp_fifo_full.
  - r_dp_ready_o = port_r_dp_ready_i[h] under the same conditions.
  - On a handshake: pop meta_fifo and push h into dp_fifo.
- Data and response stage, with a = dp_fifo head:
  - buffer_in_o and buffer_in_valid_o come from port a; buffer_in_ready_i is routed only to port a.
  - All other ports see ready '0; all data outputs are '0 when dp_fifo is empty.
  - r_dp_rsp_o, r_dp_rsp_valid_o and port_r_dp_rsp_ready_o[a] follow the same steering.
  - A response handshake pops dp_fifo.
- Latency: purely combinational steering, zero cycles; state updates on the clock edge.
- Full FIFO blocks a push even if a pop occurs in the same cycle, so there is no ready-to-ready combinational path.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and the count is unchanged.
- busy_o = !meta_fifo_empty | !dp_fifo_empty.
- Valid/ready on every interface is AXI-style: valid is never dependent on the matching ready.
- A port whose index is not at a FIFO head never receives a valid or ready.
- Reset asserted mid-transfer discards all outstanding entries immediately; no flush handshake is issued.
- Assertions: no pop when empty, no push when full, NumPorts in 1..16.

Decomposition:
- idma_pkg gets a port_idx_t helper (PW-bit index type) and a NumReadPortsMax = 16 constant.
- One natural sub-module, instantiated twice: idma_port_order_fifo. It is a parameter-depth FIFO of port_idx_t with push/pop/full/empty. A common_cells fifo_v3 may be used in its place.

Test Plan:
- Round-robin: NumPorts=3, 4 meta requests, all ports ready -> port_meta_valid_o pulses 001, 010, 100, 001; rr_q ends at 1.
- Stall: port 1 ready held 0 for 5 cycles while it is targeted -> meta_ready_o 0 for those 5 cycles, no request reaches port 2, rr_q stays 1.
- Full FIFO: NumAxInFlight=2, 3 meta requests with no r_dp requests -> third request sees meta_ready_o=0; one r_dp handshake -> next cycle meta_ready_o=1.
- Data steering: transfers on ports 0 then 1; port 1 drives data 0xBEEF early -> buffer_in_o shows port 0 data until port 0's response pops, then 0xBEEF; port_buffer_in_ready_o[1] is '0 until then.
- Response ordering: port 1 response valid before port 0 -> r_dp_rsp_valid_o stays 0 until port 0 responds; responses emerge in order 0, 1.
- Reset mid-operation: assert rst_ni=0 with 2 entries outstanding -> busy_o=0 and all valids 0 in the same cycle; first post-reset request goes to port 0.
